// File: rtl/sort_pkg.sv
// Shared types for the 6-lane sorting network and its stream sequencer.
package sort_pkg;

  localparam int N_LANES = 6;

  typedef logic [31:0] data_t;

  typedef data_t [N_LANES-1:0] lanes_t;

  typedef enum logic [1:0] {
    FILL,
    SORT,
    DRAIN
  } state_e;

endpackage

// File: rtl/sort_6_12_5.sv
// Combinational 6-input ascending sorting network: 12 compare-exchange elements, depth 5.
module sort_6_12_5
  import sort_pkg::*;
(
  input  logic   clk_i,
  input  lanes_t data_i,
  output lanes_t data_o
);

  localparam int N_CMP = 12;

  // Comparator pairs listed layer by layer; the lower index always receives the minimum.
  localparam int LO[N_CMP] = '{0, 1, 2, 1, 3, 0, 2, 0, 2, 4, 1, 3};
  localparam int HI[N_CMP] = '{5, 3, 4, 2, 4, 3, 5, 1, 3, 5, 2, 4};

  lanes_t v;
  data_t  t;

  always_comb begin
    v = data_i;
    t = '0;
    for (int k = 0; k < N_CMP; k++) begin
      if (v[LO[k]] > v[HI[k]]) begin
        t        = v[LO[k]];
        v[LO[k]] = v[HI[k]];
        v[HI[k]] = t;
      end
    end
    data_o = v;
  end

  for (genvar g = 0; g < N_LANES - 1; g++) begin : g_order
    a_ascending: assert property (@(posedge clk_i) data_o[g] <= data_o[g+1]);
  end

endmodule

// File: rtl/sort_6_stream_ctrl.sv
// Stream-to-batch sequencer around one sort_6_12_5 network: FILL -> SORT -> DRAIN.
// Define SORT_6_STREAM_DESCENDING_EN to drain largest-first instead of ascending.
module sort_6_stream_ctrl
  import sort_pkg::*;
#(
  parameter data_t PAD_VALUE = 32'hFFFF_FFFF
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  in_valid,
  output logic  in_ready,
  input  data_t in_data,
  input  logic  in_last,
  output logic  out_valid,
  input  logic  out_ready,
  output data_t out_data,
  output logic  out_last,
  output logic  busy
);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] rd_idx_q, rd_idx_d;
  logic [2:0] len_q, len_d;
  lanes_t     lane_q, lane_d;
  lanes_t     sorted_q, sorted_d;
  lanes_t     net_out;
  logic [2:0] rd_sel;
  logic       is_last;

  sort_6_12_5 u_net (
    .clk_i  (clk),
    .data_i (lane_q),
    .data_o (net_out)
  );

  assign is_last = (rd_idx_q == len_q - 3'd1);

`ifdef SORT_6_STREAM_DESCENDING_EN
  // Walk down from the largest real word so pad lanes above it are never read.
  assign rd_sel = len_q - 3'd1 - rd_idx_q;
`else
  assign rd_sel = rd_idx_q;
`endif

  always_comb begin
    in_ready  = (state_q == FILL);
    out_valid = (state_q == DRAIN);
    busy      = (state_q != FILL);
    out_last  = out_valid && is_last;
    out_data  = out_valid ? sorted_q[rd_sel] : '0;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_idx_d = rd_idx_q;
    len_d    = len_q;
    lane_d   = lane_q;
    sorted_d = sorted_q;
    case (state_q)
      FILL: begin
        if (in_valid) begin
          for (int i = 0; i < N_LANES; i++) begin
            if (cnt_q == 3'(i)) lane_d[i] = in_data;
          end
          cnt_d = cnt_q + 3'd1;
          if (in_last || (cnt_q == 3'(N_LANES - 1))) begin
            len_d   = cnt_q + 3'd1;
            state_d = SORT;
          end
        end
      end
      SORT: begin
        // Lanes are re-padded here so a following short batch sees no stale words.
        sorted_d = net_out;
        lane_d   = {N_LANES{PAD_VALUE}};
        cnt_d    = 3'd0;
        rd_idx_d = 3'd0;
        state_d  = DRAIN;
      end
      DRAIN: begin
        if (out_ready) begin
          rd_idx_d = rd_idx_q + 3'd1;
          if (is_last) state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FILL;
      cnt_q    <= 3'd0;
      rd_idx_q <= 3'd0;
      len_q    <= 3'd0;
      lane_q   <= {N_LANES{PAD_VALUE}};
      sorted_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_idx_q <= rd_idx_d;
      len_q    <= len_d;
      lane_q   <= lane_d;
      sorted_q <= sorted_d;
    end
  end

endmodule
